b2a_sched: RTL and testbench
============================

# b2a_sched

Issue controller for the pipelined Boolean-to-arithmetic mask converter (n-share, k-bit). It arbitrates round-robin among `NREQ` requesters and issues at most one conversion per cycle into the core. It gates the core's global enable from randomness availability and output backpressure, tracks a requester ID alongside each in-flight conversion, and can drain the pipeline to idle on request. It sits between the requesting cipher engines, the TRNG/PRNG randomness stream, and one converter core instance.

## Interface
- `K_WIDTH`, 32, share width in bits
- `N_SHARES`, 3, number of shares
- `MASKWIDTH`, `K_WIDTH*N_SHARES`, masked word width
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, `$clog2(NREQ)`, requester ID width
- `LAT`, 30, core latency in enabled cycles (issue to core `o_dvld`)

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `req_vld_i`  in  `NREQ`  per-requester request valid
- `req_b_i`  in  `NREQ*MASKWIDTH`  per-requester Boolean-masked operand
- `req_rdy_o`  out  `NREQ`  one-hot grant, accepted when `vld&rdy`
- `rnd_vld_i`  in  1  fresh randomness word bundle present at core `i_n`
- `rnd_rdy_o`  out  1  randomness consumed this cycle (= core enable)
- `core_dvld_o`  out  1  to core `i_dvld`
- `core_rvld_o`  out  1  to core `i_rvld` (global pipeline enable)
- `core_b_o`  out  `MASKWIDTH`  to core `i_b`
- `core_dvld_i`  in  1  from core `o_dvld`
- `core_a_i`  in  `MASKWIDTH`  from core `o_a`
- `out_vld_o`  out  1  result valid
- `out_a_o`  out  `MASKWIDTH`  arithmetic shares
- `out_id_o`  out  `IDW`  originating requester
- `out_rdy_i`  in  1  downstream ready
- `quiesce_i`  in  1  stop accepting, drain
- `idle_o`  out  1  no conversion in flight, not accepting
- `inflight_o`  out  `$clog2(LAT+1)`  conversions in flight

## Operation
- Enable: `en = rnd_vld_i & ~(core_dvld_i & ~out_rdy_i)`; `core_rvld_o = rnd_rdy_o = en`. One randomness bundle is consumed per enabled cycle, whether or not a request is issued.
- FSM states:
  - RUN: accept requests.
  - DRAIN: no new issue; go to IDLE when `inflight_o==0`.
  - IDLE: `idle_o=1`.
- Transitions:
  - RUN→DRAIN when `quiesce_i`.
  - DRAIN→IDLE when count is 0 (DRAIN→IDLE in the same cycle the count reaches 0 on a retire).
  - IDLE→RUN when `~quiesce_i`.
  - DRAIN→RUN when `~quiesce_i`, even before empty.
- Arbitration: round-robin over `req_vld_i`, starting at pointer `ptr`. Grant only in RUN and only when `en`. `req_rdy_o` is the grant vector (one-hot or zero). The pointer moves to grant+1 mod `NREQ` after each grant and holds otherwise.
- Issue: `core_dvld_o` = any grant, `core_b_o` = granted operand (zero when no grant).
- ID tracking: an `LAT`-deep shift line of {valid, ID} advances only when `en`. The head ID drives `out_id_o`.
- Output: `out_vld_o = core_dvld_i`, `out_a_o = core_a_i`. A result retires when `out_vld_o & out_rdy_i`.
- Counter: `inflight_o` +1 on issue, −1 on retire, unchanged when both or neither. It never exceeds `LAT`.
- Consistency check (assertion): `core_dvld_i` equals the head valid bit of the ID line.

## Timing
- Reset values:
  - FSM = RUN, `ptr=0`, ID line cleared, counter 0.
  - `req_rdy_o=0`, `rnd_rdy_o=0`, `core_dvld_o=0`, `core_rvld_o=0`, `idle_o=0`, `out_vld_o=0`.
- Request-to-grant is combinational, same cycle. A requester may drop `vld` only after acceptance.
- Latency: a request accepted in enabled cycle t appears at the output after exactly `LAT` further enabled cycles. Disabled cycles stretch latency one-for-one.
- Backpressure: while the output is valid and not ready, `en=0`. The whole core freezes, `out_*` hold stable, and no randomness is consumed.
- Randomness gap (`rnd_vld_i=0`): the core freezes and no grant is issued. Held output is unaffected.
- Throughput: one conversion per cycle under continuous randomness and `out_rdy_i=1`.
- Simultaneous `quiesce_i` and request in the same cycle: the request is not granted.
- Reset mid-operation: all in-flight IDs are discarded. The core is reset by the same `rst_ni`, so no stale result emerges.

## Structure
- Shared package `b2a_pkg`:
  - `K_WIDTH`, `N_SHARES`, and `LAT` defaults.
  - FSM state enum {RUN, DRAIN, IDLE}.
- Sub-module `b2a_tagline`: enable-gated `LAT`-stage {valid, ID} delay line, built from the codebase's enable-gated register primitive.
- The round-robin arbiter stays inline.

## Test plan
- Single request from req 2 (`b=0x…` shares XOR to 0x12345678), `rnd_vld=1`, `out_rdy=1` → `out_vld` 30 cycles later, `out_id=2`, shares sum mod 2^32 to 0x12345678.
- All 4 requesters held valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3; outputs return in the same order with matching IDs, one per cycle.
- `rnd_vld_i` low for 5 cycles mid-stream → no grants and `rnd_rdy_o=0` during the gap; every result latency becomes 35 cycles.
- `out_rdy_i` low for 3 cycles while `out_vld=1` → `out_a`/`out_id` stable, `core_rvld_o=0`, no grants; the stream resumes with no loss or duplication.
- `quiesce_i` with 10 in flight → no new grants; `inflight_o` counts 10→0; `idle_o` rises in the cycle after the last retire. Dropping `quiesce_i` returns to RUN.
- Assert `rst_ni` with 20 in flight → all outputs take their reset values immediately; after release, no stray `out_vld` appears within 40 cycles.

Source files
------------

// File: rtl/b2a_pkg.sv
// Shared defaults and FSM state encoding for the Boolean-to-arithmetic
// converter issue controller.
package b2a_pkg;
  localparam int B2A_K_WIDTH  = 32;
  localparam int B2A_N_SHARES = 3;
  localparam int B2A_LAT      = 30;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} b2a_state_e;
endpackage

// File: rtl/b2a_tagline.sv
// Enable-gated {valid, ID} delay line that mirrors the converter core's
// pipeline occupancy. It is built from a generic enable-gated register.
module b2a_en_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
endmodule

module b2a_tagline #(
  parameter int LAT = 30,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_vld,
  input  logic [IDW-1:0] in_id,
  output logic           head_vld,
  output logic [IDW-1:0] head_id
);
  logic [LAT:0][IDW:0] stg;

  assign stg[0] = {in_vld, in_id};

  for (genvar i = 0; i < LAT; i++) begin : g_stg
    b2a_en_reg #(.W(IDW + 1)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (stg[i]),
      .q     (stg[i+1])
    );
  end

  assign {head_vld, head_id} = stg[LAT];
endmodule

// File: rtl/b2a_sched.sv
// Issue controller for the pipelined B2A converter: round-robin issue,
// global enable gating, requester-ID tracking and drain-to-idle.
module b2a_sched
  import b2a_pkg::*;
#(
  parameter int K_WIDTH   = B2A_K_WIDTH,
  parameter int N_SHARES  = B2A_N_SHARES,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
  parameter int NREQ      = 4,
  parameter int IDW       = $clog2(NREQ),
  parameter int LAT       = B2A_LAT
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NREQ-1:0]                req_vld_i,
  input  logic [NREQ-1:0][MASKWIDTH-1:0] req_b_i,
  output logic [NREQ-1:0]                req_rdy_o,
  input  logic                           rnd_vld_i,
  output logic                           rnd_rdy_o,
  output logic                           core_dvld_o,
  output logic                           core_rvld_o,
  output logic [MASKWIDTH-1:0]           core_b_o,
  input  logic                           core_dvld_i,
  input  logic [MASKWIDTH-1:0]           core_a_i,
  output logic                           out_vld_o,
  output logic [MASKWIDTH-1:0]           out_a_o,
  output logic [IDW-1:0]                 out_id_o,
  input  logic                           out_rdy_i,
  input  logic                           quiesce_i,
  output logic                           idle_o,
  output logic [$clog2(LAT+1)-1:0]       inflight_o
);
  localparam int CW = $clog2(LAT + 1);

  b2a_state_e     state, state_nxt;
  logic [IDW-1:0] ptr, gnt_id, idx;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           en, found, issue, retire, head_vld;

  // Reset gating keeps the enable low while the core is held in reset.
  assign en          = rst_ni & rnd_vld_i & ~(core_dvld_i & ~out_rdy_i);
  assign rnd_rdy_o   = en;
  assign core_rvld_o = en;

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_vld_i[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign issue       = (state == ST_RUN) & en & ~quiesce_i & found;
  assign core_dvld_o = issue;
  assign core_b_o    = issue ? req_b_i[gnt_id] : '0;

  always_comb begin
    req_rdy_o = '0;
    if (issue) req_rdy_o[gnt_id] = 1'b1;
  end

  // A result only leaves once the frozen core is allowed to advance.
  assign retire    = core_dvld_i & out_rdy_i & en;
  assign out_vld_o = core_dvld_i;
  assign out_a_o   = core_a_i;

  always_comb begin
    cnt_nxt = cnt;
    if (issue && !retire)      cnt_nxt = cnt + 1'b1;
    else if (!issue && retire) cnt_nxt = cnt - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (quiesce_i) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!quiesce_i)          state_nxt = ST_RUN;
                else if (cnt_nxt == '0)  state_nxt = ST_IDLE;
      ST_IDLE:  if (!quiesce_i) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= ST_RUN;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (issue) ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : IDW'(gnt_id + 1'b1);
    end

  assign idle_o     = (state == ST_IDLE);
  assign inflight_o = cnt;

  b2a_tagline #(.LAT(LAT), .IDW(IDW)) u_tagline (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .en       (en),
    .in_vld   (issue),
    .in_id    (gnt_id),
    .head_vld (head_vld),
    .head_id  (out_id_o)
  );

  a_head_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    core_dvld_i == head_vld);
endmodule

// File: tb/tb_b2a_sched.sv
// Randomized bench for b2a_sched with a behavioural converter core and a
// queue-based reference model of issue order, latency and drain behaviour.
module tb_b2a_sched;
  localparam int K = 32, NS = 3, MW = K * NS, NREQ = 4, IDW = 2, LAT = 30;
  localparam int CW = $clog2(LAT + 1);

  logic                    clk_i = 1'b0, rst_ni = 1'b0;
  logic [NREQ-1:0]         req_vld = '0, req_rdy;
  logic [NREQ-1:0][MW-1:0] req_b = '0;
  logic                    rnd_vld = 1'b0, rnd_rdy, c_dvld_o, c_rvld_o, c_dvld_i;
  logic                    out_vld, out_rdy = 1'b0, quiesce = 1'b0, idle;
  logic [MW-1:0]           c_b_o, c_a_i, out_a;
  logic [IDW-1:0]          out_id;
  logic [CW-1:0]           inflight;

  int n_tests = 0, n_fail = 0;

  always #5 clk_i = ~clk_i;

  b2a_sched #(.K_WIDTH(K), .N_SHARES(NS), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_vld_i(req_vld), .req_b_i(req_b),
    .req_rdy_o(req_rdy), .rnd_vld_i(rnd_vld), .rnd_rdy_o(rnd_rdy),
    .core_dvld_o(c_dvld_o), .core_rvld_o(c_rvld_o), .core_b_o(c_b_o),
    .core_dvld_i(c_dvld_i), .core_a_i(c_a_i), .out_vld_o(out_vld),
    .out_a_o(out_a), .out_id_o(out_id), .out_rdy_i(out_rdy),
    .quiesce_i(quiesce), .idle_o(idle), .inflight_o(inflight));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] mask(input logic [K-1:0] x);
    logic [K-1:0] r0, r1;
    r0 = $urandom; r1 = $urandom;
    return {x ^ r0 ^ r1, r1, r0};
  endfunction

  function automatic logic [K-1:0] bool_val(input logic [MW-1:0] b);
    return b[0 +: K] ^ b[K +: K] ^ b[2*K +: K];
  endfunction

  function automatic logic [K-1:0] arith_val(input logic [MW-1:0] a);
    return a[0 +: K] + a[K +: K] + a[2*K +: K];
  endfunction

  function automatic logic [MW-1:0] to_arith(input logic [MW-1:0] b);
    logic [K-1:0] r0, r1;
    r0 = $urandom; r1 = $urandom;
    return {bool_val(b) - r0 - r1, r1, r0};
  endfunction

  // Converter core stand-in: LAT enabled stages, reset with the controller.
  logic [LAT-1:0] cv;
  logic [MW-1:0]  ca [LAT];
  always @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cv <= '0;
      for (int i = 0; i < LAT; i++) ca[i] <= '0;
    end else if (c_rvld_o) begin
      cv <= {cv[LAT-2:0], c_dvld_o};
      for (int i = 1; i < LAT; i++) ca[i] <= ca[i-1];
      ca[0] <= to_arith(c_b_o);
    end
  assign c_dvld_i = cv[LAT-1];
  assign c_a_i    = ca[LAT-1];

  // Reference model: in-flight entries age by enabled edges since issue.
  typedef struct { int id; logic [K-1:0] x; int age; } ent_t;
  ent_t            q[$];
  int              m_mode = 0, m_ptr = 0, g;
  bit              ov, en;
  logic [NREQ-1:0] eg, last_gnt = '0;
  logic [MW-1:0]   eb;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("rst_rdy", req_rdy, 0);   chk("rst_rnd", rnd_rdy, 0);
      chk("rst_dvld", c_dvld_o, 0); chk("rst_rvld", c_rvld_o, 0);
      chk("rst_idle", idle, 0);     chk("rst_ovld", out_vld, 0);
      chk("rst_infl", inflight, 0);
      q.delete(); m_mode = 0; m_ptr = 0; last_gnt = '0;
    end else begin
      ov = q.size() > 0 && q[0].age == LAT;
      en = rnd_vld && !(ov && !out_rdy);
      g  = -1;
      if (m_mode == 0 && en && !quiesce)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_vld[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      eg = '0; eb = '0;
      if (g >= 0) begin eg[g] = 1'b1; eb = req_b[g]; end
      chk("rnd_rdy", rnd_rdy, en);  chk("rvld", c_rvld_o, en);
      chk("gnt", req_rdy, eg);      chk("dvld", c_dvld_o, g >= 0);
      chk("core_b", c_b_o, eb);     chk("out_vld", out_vld, ov);
      if (ov) begin
        chk("out_id", out_id, q[0].id);
        chk("out_sum", arith_val(out_a), q[0].x);
      end
      chk("inflight", inflight, q.size());
      chk("idle", idle, m_mode == 2);
      last_gnt = eg;
      if (en) begin
        if (ov && out_rdy) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (g >= 0) begin
          q.push_back('{g, bool_val(req_b[g]), 1});
          m_ptr = (g + 1) % NREQ;
        end
      end
      case (m_mode)
        0: if (quiesce) m_mode = 1;
        1: if (!quiesce) m_mode = 0; else if (q.size() == 0) m_mode = 2;
        default: if (!quiesce) m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // A requester only refreshes or drops its request after it was accepted.
  task automatic drive_reqs(input int p_req);
    for (int i = 0; i < NREQ; i++)
      if (last_gnt[i] || !req_vld[i]) begin
        req_vld[i] = ($urandom_range(99) < p_req);
        req_b[i]   = mask($urandom);
      end
  endtask

  task automatic run(input int n, input int p_req, input int p_rnd, input int p_rdy);
    repeat (n) begin
      drive_reqs(p_req);
      rnd_vld = ($urandom_range(99) < p_rnd);
      out_rdy = ($urandom_range(99) < p_rdy);
      tick();
    end
  endtask

  task automatic flush();
    for (int n = 0; n < 50 && req_vld != '0; n++) begin
      drive_reqs(0); rnd_vld = 1'b1; out_rdy = 1'b1; tick();
    end
    chk("flush_reqs", req_vld, 0);
    run(LAT + 5, 0, 100, 100);
    chk("flush_empty", inflight, 0);
  endtask

  // One request, optionally with a randomness gap; returns latency in cycles.
  task automatic single(input int id, input logic [K-1:0] x, input int gap, output int n);
    req_b[id] = mask(x); req_vld[id] = 1'b1; n = 0;
    do begin tick(); n++; end while (!last_gnt[id] && n < 10);
    chk("single_gnt", last_gnt[id], 1);
    req_vld[id] = 1'b0; n = 1;
    while (!out_vld && n < 100) begin
      rnd_vld = !(n >= 3 && n < 3 + gap);
      tick(); n++;
    end
    rnd_vld = 1'b1;
    chk("single_id", out_id, id);
    chk("single_sum", arith_val(out_a), x);
  endtask

  int lat, cnt;
  logic [MW-1:0]  a0;
  logic [IDW-1:0] id0;

  initial begin
    rnd_vld = 1'b1; out_rdy = 1'b1;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    single(2, 32'h1234_5678, 0, lat);
    chk("lat_nominal", lat, LAT);
    single(1, $urandom, 5, lat);
    chk("lat_gap", lat, LAT + 5);

    cnt = 0;
    repeat (8) begin
      drive_reqs(100); tick();
      cnt += $countones(last_gnt);
    end
    chk("throughput", cnt, 8);
    flush();

    run(LAT + 5, 100, 100, 100);
    chk("bp_vld", out_vld, 1);
    a0 = out_a; id0 = out_id; out_rdy = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_a", out_a, a0); chk("bp_id", out_id, id0);
    end
    run(10, 100, 100, 100);
    flush();

    run(10, 100, 100, 100);
    chk("q_infl10", inflight, 10);
    quiesce = 1'b1;
    for (int n = 0; n < 100 && !idle; n++) begin drive_reqs(100); tick(); end
    chk("q_idle", idle, 1);
    chk("q_empty", inflight, 0);
    quiesce = 1'b0;
    run(5, 100, 100, 100);
    chk("q_resume", inflight != 0, 1);

    repeat (1500) begin
      if ($urandom_range(99) < 2) quiesce = ~quiesce;
      run(1, 60, 80, 70);
    end
    quiesce = 1'b0;
    flush();

    run(25, 100, 100, 100);
    rst_ni = 1'b0; #1;
    chk("arst_rdy", req_rdy, 0); chk("arst_rnd", rnd_rdy, 0);
    chk("arst_ovld", out_vld, 0); chk("arst_infl", inflight, 0);
    req_vld = '0;
    tick(); tick();
    rst_ni = 1'b1;
    cnt = 0;
    repeat (40) begin tick(); if (out_vld) cnt++; end
    chk("no_stray", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1);
  end
endmodule
